alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 52 +++++
 rtl/cond_eval.sv | 29 ++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state and condition encodings for the ALU sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_DONE   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    COND_Z  = 3'd0,
    COND_NZ = 3'd1,
    COND_C  = 3'd2,
    COND_NC = 3'd3,
    COND_N  = 3'd4,
    COND_NN = 3'd5,
    COND_P  = 3'd6,
    COND_NP = 3'd7
  } cond_t;

  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_ALU  = 3'd1,
    K_LOAD = 3'd2,
    K_JMP  = 3'd3,
    K_JCC  = 3'd4,
    K_HALT = 3'd5,
    K_ILL  = 3'd6
  } kind_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JCC  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Classify the low opcode nibble; 0x1-0x7 are ALU functions, 0xB-0xE are unassigned.
  function automatic kind_t decode_op(input logic [3:0] op);
    kind_t k;
    k = K_ILL;
    if (op == OP_NOP)                      k = K_NOP;
    else if (op >= 4'h1 && op <= 4'h7)     k = K_ALU;
    else if (op == OP_LOAD)                k = K_LOAD;
    else if (op == OP_JMP)                 k = K_JMP;
    else if (op == OP_JCC)                 k = K_JCC;
    else if (op == OP_HALT)                k = K_HALT;
    return k;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - branch condition evaluation against the flag register
module cond_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       taken
);

  // Select the flag named by cond, inverted for the odd encodings.
  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_Z:  taken = Z;
      COND_NZ: taken = !Z;
      COND_C:  taken = C;
      COND_NC: taken = !C;
      COND_N:  taken = N;
      COND_NN: taken = !N;
      COND_P:  taken = P;
      COND_NP: taken = !P;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-cycle instruction sequencer driving ALU, accumulator, flag and PC strobes
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     cond,
  input  logic           C,
  input  logic           N,
  input  logic           P,
  input  logic           Z,
  output logic [2:0]     alu_op,
  output logic           acc_en,
  output logic           enaf,
  output logic           pc_load,
  output logic           done,
  output logic           err,
  output logic           halted
);

  state_t         state, state_nx;
  logic [OPW-1:0] op_q;
  logic [2:0]     cond_q;
  kind_t          kind;
  logic           taken;

  logic [2:0]     alu_op_nx;
  logic           acc_en_nx, enaf_nx, pc_load_nx, err_nx;

  // Opcodes wider than a nibble are only legal when the extra bits are zero.
  assign kind = ((op_q >> 4) == '0) ? decode_op(op_q[3:0]) : K_ILL;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .C     (C),
    .N     (N),
    .P     (P),
    .Z     (Z),
    .taken (taken)
  );

  // State register; reset always wins, so an offer during reset is never accepted.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, plus the strobe values that become visible in the EXEC cycle.
  // Strobes are registered on the DECODE->EXEC edge so that no input reaches
  // an output combinationally; the branch flags are those settled at that edge.
  always_comb begin
    state_nx   = state;
    alu_op_nx  = 3'd0;
    acc_en_nx  = 1'b0;
    enaf_nx    = 1'b0;
    pc_load_nx = 1'b0;
    err_nx     = 1'b0;
    case (state)
      S_IDLE:   if (instr_valid) state_nx = S_DECODE;
      S_DECODE: begin
        if (kind == K_HALT) begin
          state_nx = S_HALT;
        end else begin
          state_nx = S_EXEC;
          case (kind)
            K_ALU: begin
              alu_op_nx = op_q[2:0];
              acc_en_nx = 1'b1;
              enaf_nx   = 1'b1;
            end
            K_LOAD:  acc_en_nx  = 1'b1;
            K_JMP:   pc_load_nx = 1'b1;
            K_JCC:   pc_load_nx = taken;
            K_ILL:   err_nx     = 1'b1;
            default: ;
          endcase
        end
      end
      S_EXEC:   state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Instruction latch: captured only on accept so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      cond_q <= 3'd0;
    end else if (state == S_IDLE && instr_valid) begin
      op_q   <= opcode;
      cond_q <= cond;
    end
  end

  // Strobe registers; each is high for the single EXEC cycle at most.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op  <= 3'd0;
      acc_en  <= 1'b0;
      enaf    <= 1'b0;
      pc_load <= 1'b0;
      err     <= 1'b0;
    end else begin
      alu_op  <= alu_op_nx;
      acc_en  <= acc_en_nx;
      enaf    <= enaf_nx;
      pc_load <= pc_load_nx;
      err     <= err_nx;
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_DONE);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [2:0] cond;
  logic       C, N, P, Z;
  logic [2:0] alu_op;
  logic       acc_en, enaf, pc_load, done, err, halted;

  int checks = 0;
  int errors = 0;

  logic [9:0] obs;

  alu_sequencer #(.OPW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .cond        (cond),
    .C           (C),
    .N           (N),
    .P           (P),
    .Z           (Z),
    .alu_op      (alu_op),
    .acc_en      (acc_en),
    .enaf        (enaf),
    .pc_load     (pc_load),
    .done        (done),
    .err         (err),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign obs = {instr_ready, alu_op, acc_en, enaf, pc_load, done, err, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (rdy,aluop,acc,enaf,pc,done,err,halt)", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pack(input bit rdy, input logic [2:0] aop, input bit acc,
                                      input bit fl, input bit pc, input bit dn,
                                      input bit er, input bit hl);
    return {rdy, aop, acc, fl, pc, dn, er, hl};
  endfunction

  // Flags are packed {C,N,P,Z}.
  function automatic bit cond_holds(input int c, input logic [3:0] f);
    bit cf, nf, pf, zf;
    cf = f[3]; nf = f[2]; pf = f[1]; zf = f[0];
    case (c)
      0: return zf;
      1: return !zf;
      2: return cf;
      3: return !cf;
      4: return nf;
      5: return !nf;
      6: return pf;
      default: return !pf;
    endcase
  endfunction

  // What the EXEC cycle should look like for one instruction.
  function automatic logic [9:0] exec_expect(input int op, input int c, input logic [3:0] f);
    logic [2:0] a;
    a = 3'(op);
    if (op >= 1 && op <= 7) return pack(0, a, 1, 1, 0, 0, 0, 0);
    if (op == 8)            return pack(0, 3'd0, 1, 0, 0, 0, 0, 0);
    if (op == 9)            return pack(0, 3'd0, 0, 0, 1, 0, 0, 0);
    if (op == 10)           return pack(0, 3'd0, 0, 0, cond_holds(c, f), 0, 0, 0);
    if (op >= 11 && op <= 14) return pack(0, 3'd0, 0, 0, 0, 0, 1, 0);
    if (op == 15)           return pack(0, 3'd0, 0, 0, 0, 0, 0, 1);
    return pack(0, 3'd0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Offer one non-HALT instruction at a negedge with the DUT idle, then follow
  // it through cycles 1..4. After accept the opcode/cond inputs are scrambled.
  task automatic run_instr(input int op, input int cnd, input logic [3:0] f, input bit keep);
    {C, N, P, Z} = f;
    instr_valid  = 1'b1;
    opcode       = 4'(op);
    cond         = 3'(cnd);
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
    opcode = 4'($urandom);
    cond   = 3'($urandom);
    check($sformatf("c1 op=%0h", op), 32'(obs), 32'(pack(0, 3'd0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    check($sformatf("c2 op=%0h cond=%0d f=%b", op, cnd, f), 32'(obs), 32'(exec_expect(op, cnd, f)));
    @(negedge clk);
    check($sformatf("c3 op=%0h", op), 32'(obs), 32'(pack(0, 3'd0, 0, 0, 0, 1, 0, 0)));
    @(negedge clk);
    check($sformatf("c4 op=%0h", op), 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = 4'h0; cond = 3'd0;
    {C, N, P, Z} = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    @(negedge clk);
    check("idle", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));

    // Directed cases.
    run_instr(1, 0, 4'b0000, 1'b0);           // ADD
    run_instr(10, 0, 4'b0001, 1'b0);          // JCC Z, taken
    run_instr(10, 0, 4'b0000, 1'b0);          // JCC Z, not taken
    run_instr(8, 0, 4'b1111, 1'b0);           // LOAD
    run_instr(12, 0, 4'b0000, 1'b0);          // illegal
    run_instr(9, 3, 4'b1000, 1'b0);           // JMP
    run_instr(0, 0, 4'b1111, 1'b0);           // NOP

    // Back-to-back with instr_valid held high between instructions.
    for (int i = 0; i < 6; i++)
      run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 7)), 4'($urandom), 1'b1);
    instr_valid = 1'b0;

    // Randomized mix.
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 7)), 4'($urandom),
                bit'($urandom_range(0, 1)));
    instr_valid = 1'b0;

    // Reset during EXEC abandons the instruction.
    instr_valid = 1'b1; opcode = 4'h3; cond = 3'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("rst_mid exec", 32'(obs), 32'(pack(0, 3'd3, 1, 1, 0, 0, 0, 0)));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid after", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid no done", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));

    // Reset has priority over an offered instruction.
    rst = 1'b1; instr_valid = 1'b1; opcode = 4'h1;
    @(negedge clk);
    check("rst_prio", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    check("rst_prio idle", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));

    // HALT: entered after DECODE, sticky, blocks further offers until reset.
    instr_valid = 1'b1; opcode = 4'hF; cond = 3'd0;
    @(negedge clk);
    opcode = 4'h1;
    check("halt c1", 32'(obs), 32'(pack(0, 3'd0, 0, 0, 0, 0, 0, 0)));
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("halt c%0d", i), 32'(obs), 32'(exec_expect(15, 0, 4'b0000)));
    end
    rst = 1'b1;
    @(negedge clk);
    check("halt cleared", 32'(obs), 32'(pack(1, 3'd0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    run_instr(5, 0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
